// File: rtl/gcd_arb_pkg.sv
// Shared definitions for the GCD share arbiter: FSM state encoding and
// default widths/limits used when the top is instantiated without overrides.
package gcd_arb_pkg;

  localparam int GCD_DATA_W  = 16;
  localparam int GCD_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping to 0. Returns a one-hot grant and its binary index.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    // pass 1 scans ptr..N_REQ-1, pass 2 wraps through the low indices
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[i] && (IDX_W'(i) >= ptr)) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[i]) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/gcd_share_arbiter.sv
// Shares a single GCD datapath between N_REQ clients: round-robin grant,
// operand latch, Begin pulse, Complete rising-edge capture and a WAIT timeout.
module gcd_share_arbiter
  import gcd_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = GCD_DATA_W,
  parameter int TIMEOUT = GCD_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] a_in,
  input  logic [N_REQ*DATA_W-1:0] b_in,
  output logic [N_REQ-1:0]        ack,
  output logic [N_REQ-1:0]        done,
  output logic [DATA_W-1:0]       result,
  output logic                    err,
  output logic                    busy,
  output logic                    gcd_begin,
  output logic [DATA_W-1:0]       gcd_a,
  output logic [DATA_W-1:0]       gcd_b,
  input  logic                    gcd_complete,
  input  logic [DATA_W-1:0]       gcd_result
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int TMR_W = $clog2(TIMEOUT);

  arb_state_e                   state, state_nxt;
  logic [IDX_W-1:0]             ptr, arb_idx;
  logic [N_REQ-1:0]             arb_grant, gnt_oh;
  logic [TMR_W-1:0]             timer;
  logic                         complete_d, err_pend;
  logic                         any_req, cmp_rise, tmo;
  logic [N_REQ-1:0][DATA_W-1:0] a_vec, b_vec;

  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign a_vec[i] = a_in[i*DATA_W +: DATA_W];
    assign b_vec[i] = b_in[i*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req       (req),
    .ptr       (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign any_req  = |req;
  // a Complete level still high from the previous op must not count
  assign cmp_rise = gcd_complete & ~complete_d;
  assign tmo      = (timer == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (any_req) state_nxt = ST_START;
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT:  if (cmp_rise || tmo) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack        <= '0;
      gcd_begin  <= 1'b0;
      gcd_a      <= '0;
      gcd_b      <= '0;
      result     <= '0;
      ptr        <= '0;
      gnt_oh     <= '0;
      timer      <= '0;
      complete_d <= 1'b0;
      err_pend   <= 1'b0;
    end else begin
      ack        <= '0;
      gcd_begin  <= 1'b0;
      complete_d <= gcd_complete;
      unique case (state)
        ST_IDLE: begin
          if (any_req) begin
            gnt_oh <= arb_grant;
            ack    <= arb_grant;
            gcd_a  <= a_vec[arb_idx];
            gcd_b  <= b_vec[arb_idx];
            ptr    <= (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
          end
        end
        ST_START: begin
          gcd_begin <= 1'b1;
          timer     <= '0;
          err_pend  <= 1'b0;
        end
        ST_WAIT: begin
          if (cmp_rise) begin
            result <= gcd_result;
          end else if (tmo) begin
            result   <= '0;
            err_pend <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign done = (state == ST_RESP) ? gnt_oh : '0;
  assign err  = (state == ST_RESP) & err_pend;
  assign busy = (state != ST_IDLE);

  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack));
  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(done));
  assert property (@(posedge clk) disable iff (!rst_n) err |-> (done != '0));
  assert property (@(posedge clk) disable iff (!rst_n) gcd_begin |=> !gcd_begin);

endmodule

// File: tb/tb_gcd_share_arbiter.sv
// Bench for gcd_share_arbiter: behavioural GCD unit with programmable latency,
// table-driven single ops, hand sequences for arbitration/stale/timeout/reset, random soak.
module tb_gcd_share_arbiter;

  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int W   = 16;
  localparam int TMO = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0][W-1:0] a_arr = '0, b_arr = '0;
  logic [N*W-1:0] a_in, b_in;
  logic [N-1:0]   ack, done;
  logic [W-1:0]   result, gcd_a, gcd_b, gcd_result;
  logic           err, busy, gcd_begin, gcd_complete;

  assign a_in = a_arr;
  assign b_in = b_arr;

  always #5 clk = ~clk;

  gcd_share_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
    .ack(ack), .done(done), .result(result), .err(err), .busy(busy),
    .gcd_begin(gcd_begin), .gcd_a(gcd_a), .gcd_b(gcd_b),
    .gcd_complete(gcd_complete), .gcd_result(gcd_result)
  );

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  function automatic logic [N-1:0] oh(input int c);
    logic [N-1:0] v;
    v = '0;
    v[IW'(c)] = 1'b1;
    return v;
  endfunction

  // behavioural GCD unit: latency m_lat after Begin, Complete held m_hold cycles
  int         m_lat = 0, m_hold = 1;
  bit         m_never = 1'b0;
  logic       m_pend;
  int         m_cnt, m_hcnt;
  logic [W-1:0] m_val;
  logic       m_fire;
  assign m_fire = m_pend && !m_never && (m_cnt == 0) && !gcd_begin;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 1'b0; m_cnt <= 0; m_hcnt <= 0; m_val <= '0;
      gcd_complete <= 1'b0; gcd_result <= '0;
    end else begin
      if (gcd_begin) begin
        m_pend <= 1'b1; m_cnt <= m_lat; m_val <= ref_gcd(gcd_a, gcd_b);
      end else if (m_pend && !m_never && m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
      end
      if (m_fire) begin
        m_pend <= 1'b0; gcd_complete <= 1'b1; gcd_result <= m_val; m_hcnt <= m_hold - 1;
      end else if (m_hcnt > 0) begin
        m_hcnt <= m_hcnt - 1;
      end else begin
        gcd_complete <= 1'b0;
      end
    end
  end

  typedef struct { int cl; logic [W-1:0] val; logic er; } exp_t;
  typedef struct { int cl; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] exp; int lat; } vec_t;

  exp_t sb[$];
  int   ack_log[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, n_begin = 0, oh_bad = 0;
  int   ack_cyc = 0, done_cyc = 0, begin_cyc = 0, done_tot = 0;
  int   ack_cnt[N], done_cnt[N];
  logic [2:0] c_hist = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic sb_pop(input int cl);
    int k;
    k = -1;
    for (int j = 0; j < sb.size(); j++) if (k < 0 && sb[j].cl == cl) k = j;
    if (k < 0) begin
      n_chk++; n_fail++;
      $display("FAIL unexpected_done: client %0d result 0x%0h, required no done", cl, result);
    end else begin
      chk($sformatf("sb_result_c%0d", cl), 64'(result), 64'(sb[k].val));
      chk($sformatf("sb_err_c%0d", cl), 64'(err), 64'(sb[k].er));
      sb.delete(k);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    c_hist = {c_hist[1:0], gcd_complete};
    if (gcd_begin) begin n_begin++; begin_cyc = cyc; end
    if (!$onehot0(ack) || !$onehot0(done) || (err && done == '0)) oh_bad++;
    for (int i = 0; i < N; i++) begin
      if (ack[IW'(i)]) begin ack_cnt[i]++; ack_log.push_back(i); ack_cyc = cyc; end
      if (done[IW'(i)]) begin done_cnt[i]++; done_tot++; done_cyc = cyc; sb_pop(i); end
    end
  endtask

  task automatic wait_ack(input int budget, input string nm);
    int n;
    n = 0;
    tick();
    while (ack == '0 && n < budget) begin tick(); n++; end
    if (ack == '0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: no ack within %0d cycles", nm, budget);
    end
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n;
    n = 0;
    tick();
    while (done == '0 && n < budget) begin tick(); n++; end
    if (done == '0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: no done within %0d cycles", nm, budget);
    end
  endtask

  task automatic drive(input int cl, input logic [W-1:0] a, input logic [W-1:0] b, input logic er);
    exp_t e;
    a_arr[IW'(cl)] = a;
    b_arr[IW'(cl)] = b;
    req[IW'(cl)]   = 1'b1;
    e.cl = cl; e.er = er; e.val = er ? '0 : ref_gcd(a, b);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    req = '0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    int   nb, dsum, issued, guard;
    int   g, x, y;

    vt[0] = '{0, 16'd12,    16'd18,    16'd6,     0};
    vt[1] = '{1, 16'd0,     16'd25,    16'd25,    1};
    vt[2] = '{2, 16'd7,     16'd0,     16'd7,     2};
    vt[3] = '{3, 16'd0,     16'd0,     16'd0,     0};
    vt[4] = '{1, 16'd65535, 16'd65535, 16'd65535, 3};
    vt[5] = '{3, 16'd1071,  16'd462,   16'd21,    1};
    vt[6] = '{0, 16'd65521, 16'd65519, 16'd1,     4};
    vt[7] = '{2, 16'd40000, 16'd30000, 16'd10000, 0};
    for (int i = 0; i < N; i++) begin ack_cnt[i] = 0; done_cnt[i] = 0; end

    // reset state
    tick(); tick();
    chk("rst_ack", 64'(ack), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_busy_err_begin", {busy, err, gcd_begin}, 0);
    chk("rst_result_operands", {result, gcd_a, gcd_b}, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 64'(busy), 0);

    // single ops, one per table row
    for (int v = 0; v < 8; v++) begin
      m_lat = vt[v].lat; m_hold = 1;
      nb = n_begin;
      drive(vt[v].cl, vt[v].a, vt[v].b, 1'b0);
      tick();
      chk("ack_next_cycle", 64'(ack), 64'(oh(vt[v].cl)));
      chk("busy_in_op", 64'(busy), 1);
      req[IW'(vt[v].cl)] = 1'b0;
      tick();
      chk("begin_cycle2", 64'(gcd_begin), 1);
      chk("gcd_operands", {gcd_a, gcd_b}, {vt[v].a, vt[v].b});
      wait_done(64, "table_done");
      chk("done_onehot", 64'(done), 64'(oh(vt[v].cl)));
      chk("table_result", 64'(result), 64'(vt[v].exp));
      chk("ack_to_done", 64'(done_cyc - ack_cyc), 64'(4 + vt[v].lat));
      chk("done_after_edge", 64'(c_hist[2:1]), 64'(2'b01));
      tick();
      chk("done_one_cycle", 64'(done), 0);
      chk("begin_count", 64'(n_begin - nb), 1);
    end

    // round robin with two held requests and a re-raise
    do_reset();
    ack_log.delete();
    m_lat = 2;
    drive(0, 16'd48, 16'd36, 1'b0);
    drive(2, 16'd7, 16'd0, 1'b0);
    wait_ack(8, "rr_ack0");
    chk("rr_first_grant", 64'(ack), 64'(4'b0001));
    tick(); tick();
    req[0] = 1'b0;
    tick();
    drive(0, 16'd48, 16'd36, 1'b0);
    wait_done(32, "rr_done0");
    chk("rr_done0", 64'(done), 64'(4'b0001));
    wait_ack(8, "rr_ack2");
    chk("rr_second_grant", 64'(ack), 64'(4'b0100));
    req[2] = 1'b0;
    wait_done(32, "rr_done2");
    chk("rr_done2", 64'(done), 64'(4'b0100));
    wait_ack(8, "rr_ack0b");
    chk("rr_third_grant", 64'(ack), 64'(4'b0001));
    req[0] = 1'b0;
    wait_done(32, "rr_done0b");
    chk("rr_grant_order", {32'(ack_log.size()), 8'(ack_log[0]), 8'(ack_log[1]), 8'(ack_log[2])},
        {32'd3, 8'd0, 8'd2, 8'd0});

    // stale Complete level left high into the next op's WAIT
    m_hold = 6; m_lat = 0;
    drive(1, 16'd100, 16'd75, 1'b0);
    wait_ack(8, "stale_ack1");
    req[1] = 1'b0;
    tick(); tick();
    m_lat = 5;
    wait_done(32, "stale_done1");
    chk("stale_first_result", 64'(result), 25);
    nb = done_cnt[1];
    drive(1, 16'd35, 16'd14, 1'b0);
    wait_ack(8, "stale_ack2");
    req[1] = 1'b0;
    tick();
    chk("stale_level_in_wait", {gcd_begin, gcd_complete}, 2'b11);
    wait_done(40, "stale_done2");
    chk("stale_second_result", 64'(result), 7);
    m_hold = 1;
    repeat (8) tick();
    chk("stale_single_done", 64'(done_cnt[1] - nb), 1);

    // timeout: Complete never arrives
    m_never = 1'b1;
    drive(3, 16'd10, 16'd4, 1'b1);
    wait_ack(8, "tmo_ack");
    req[3] = 1'b0;
    tick();
    chk("tmo_begin", 64'(gcd_begin), 1);
    wait_done(40, "tmo_done");
    chk("tmo_done_client", 64'(done), 64'(4'b1000));
    chk("tmo_begin_to_done", 64'(done_cyc - begin_cyc), TMO);
    chk("tmo_err_result", {err, result}, {1'b1, 16'd0});
    tick();
    chk("tmo_err_pulse", {err, done}, 0);
    m_never = 1'b0;
    do_reset();

    // asynchronous reset while waiting for Complete
    m_lat = 10;
    drive(2, 16'd20, 16'd8, 1'b0);
    wait_ack(8, "ar_ack");
    req[2] = 1'b0;
    tick(); tick(); tick();
    chk("ar_in_wait", {busy, gcd_a}, {1'b1, 16'd20});
    #2 rst_n = 1'b0;
    #1;
    chk("ar_outputs_zero", {ack, done, result, err, busy, gcd_begin, gcd_a, gcd_b}, 0);
    sb.delete();
    dsum = done_tot;
    tick(); tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("ar_no_done", 64'(done_tot - dsum), 0);
    m_lat = 1;
    drive(2, 16'd9, 16'd6, 1'b0);
    wait_ack(8, "ar_ack2");
    req[2] = 1'b0;
    wait_done(32, "ar_done2");
    chk("ar_result_after", 64'(result), 3);
    tick();

    // random soak, all clients contending
    for (int i = 0; i < N; i++) begin ack_cnt[i] = 0; done_cnt[i] = 0; end
    oh_bad = 0; issued = 0; guard = 0;
    while ((issued < 2000 || sb.size() > 0 || req != '0) && guard < 60000) begin
      for (int i = 0; i < N; i++) begin
        if (!req[IW'(i)] && issued < 2000 && $urandom_range(0, 2) == 0) begin
          g = int'($urandom_range(1, 255));
          x = int'($urandom_range(0, 255));
          y = int'($urandom_range(0, 255));
          if ($urandom_range(0, 15) == 0) x = 0;
          drive(i, 16'(g * x), 16'(g * y), 1'b0);
          issued++;
        end
      end
      m_lat = int'($urandom_range(0, 6));
      tick();
      for (int i = 0; i < N; i++) if (ack[IW'(i)]) req[IW'(i)] = 1'b0;
      guard++;
    end
    repeat (10) tick();
    chk("rand_issued", 64'(issued), 2000);
    chk("rand_drained", 64'(sb.size()), 0);
    for (int i = 0; i < N; i++)
      chk($sformatf("rand_ack_eq_done_c%0d", i), 64'(ack_cnt[i]), 64'(done_cnt[i]));
    chk("onehot_ack_done_err", 64'(oh_bad), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
